// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 32x32 architectural register file.
// Selects the write-back data (load data vs ALU result), commits it to the
// register file, serves two combinational read ports for ID, and counts
// committed register writes.
// Optional feature macro: WB_BYPASS_EN. When it is defined, a write-through
// bypass returns the committing value on a read port in the same cycle.
// Register 0 is hardwired to zero in both builds.

module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,         // asynchronous, active-low
   input  logic [DATA_W-1:0] wb_read_data,
   input  logic [DATA_W-1:0] wb_alu_result,
   input  logic [ADDR_W-1:0] wb_rw,
   input  logic              wb_memtoreg,
   input  logic              wb_regwrite,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   output logic [DATA_W-1:0] busA,
   output logic [DATA_W-1:0] busB,
   output logic [DATA_W-1:0] wb_data,
   output logic [31:0]       wb_count
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [31:0]       wb_count_q;
   logic [31:0]       wb_count_d;
   logic              commit;

   // Write-back data select and commit qualifier; a write to r0 is not a commit.
   always_comb begin
      wb_data = wb_memtoreg ? wb_read_data : wb_alu_result;
      commit  = wb_regwrite && (wb_rw != '0);
   end

   // Next register-file contents: copy current state, apply the commit,
   // and keep r0 pinned at zero so its flops never hold anything else.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (commit) begin
         regs_d[wb_rw] = wb_data;
      end
      regs_d[0] = '0;
   end

   // Commit counter; wraps silently at 2^32.
   always_comb begin
      wb_count_d = wb_count_q + {31'b0, commit};
   end

   // Register-file and counter state; reset clears everything and overrides
   // any commit presented on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wb_count_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
         wb_count_q <= wb_count_d;
      end
   end

   // Combinational read ports; r0 reads zero even when bypass would match.
   always_comb begin
      busA = regs_q[ra];
      busB = regs_q[rb];
`ifdef WB_BYPASS_EN
      if (commit && (ra == wb_rw)) begin
         busA = wb_data;
      end
      if (commit && (rb == wb_rw)) begin
         busB = wb_data;
      end
`endif
      if (ra == '0) begin
         busA = '0;
      end
      if (rb == '0) begin
         busB = '0;
      end
   end

   assign wb_count = wb_count_q;

endmodule
